sig_halt_port: RTL
==================

# sig_halt_port

Memory-mapped test-completion device on the core's data-memory store path. Captures stores to a signature address into a FIFO and streams them out over a valid/ready port for dumping to a signature file. Turns a magic store into a clean `halt` that is raised only after every captured signature word has drained. Sits beside data memory in the writeback-side store path, so compliance benches consume a stream instead of probing pipeline internals.

## Interface
- `SIG_ADDR`, default 32'h0000_0F00: store address whose data is captured as a signature word.
- `HALT_ADDR`, default 32'h0000_0F04: store address that requests halt.
- `HALT_VALUE`, default 32'hCAFE_BEEF: data that must be written to `HALT_ADDR` to request halt.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 500: watchdog limit; used only under `SIG_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st_en` in 1: store strobe, one cycle per store; full-word stores only.
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data.
- `sig_valid` out 1: `sig_data` holds a valid word.
- `sig_data` out 32: FIFO head word.
- `sig_ready` in 1: consumer accepts the head word when high together with `sig_valid`.
- `sig_count` out 16: words accepted into the FIFO since reset; saturates at 16'hFFFF.
- `overflow` out 1: sticky; set when a signature store was dropped.
- `halt` out 1: sticky; test complete and FIFO empty.
- `timeout` out 1: sticky watchdog flag; constant 0 when the feature is compiled out.

## Operation
- Push: `st_en & st_addr==SIG_ADDR` while state is RUN. `st_data` is written at the tail and `sig_count` increments.
- Pop: `sig_valid & sig_ready`. The head advances.
- Full FIFO with push and no pop: the word is dropped, `overflow` is set, and `sig_count` does not increment.
- Full FIFO with push and pop in the same cycle: both succeed; occupancy is unchanged.
- Empty FIFO with push: the word is not visible combinationally; `sig_valid` rises the next cycle.
- Pointers wrap modulo `DEPTH`. Occupancy is tracked with a `log2(DEPTH)+1`-bit counter.
- Stores to any other address are ignored. A store to `HALT_ADDR` with data other than `HALT_VALUE` is ignored.
- State machine:
  - RUN -> DRAIN on `st_en & st_addr==HALT_ADDR & st_data==HALT_VALUE`.
  - DRAIN -> HALTED when occupancy is 0 at a clock edge (including 0 after that edge's pop).
  - HALTED is terminal until `rst`.
- In DRAIN and HALTED, signature pushes are ignored: not counted and they do not set `overflow`. Pops continue in DRAIN.
- `halt` = (state==HALTED), registered.
- Reset values: state RUN; pointers and occupancy 0; `sig_valid` 0; `sig_data` 0; `sig_count` 0; `overflow` 0; `halt` 0; `timeout` 0.
- Reset mid-operation discards all FIFO contents without emitting them.

## Timing
- Store at edge N: word is at the head and `sig_valid`=1 after edge N+1, when the FIFO was empty.
- Halt store at edge N with the FIFO empty: `halt`=1 after edge N+1.
- Halt store with k words queued and `sig_ready` held high: `halt`=1 one cycle after the final pop edge.
- Throughput: one push and one pop per cycle.
- `sig_data` is stable while `sig_valid & ~sig_ready`.

## Configuration
- `SIG_TIMEOUT_EN` defined:
  - A 32-bit cycle counter starts at 0 after reset and increments each cycle while not HALTED.
  - When it reaches `TIMEOUT_CYCLES`, `timeout` is set and the state forces to DRAIN. `halt` follows once the FIFO empties.
  - A halt store in the same cycle has the same effect; `timeout` is still set.
- `SIG_TIMEOUT_EN` undefined: no counter; `timeout` is tied to 0; the block halts only on the halt store.

## Test plan
- Single signature: store 32'h0000_1234 to 0xF00, `sig_ready`=1 -> `sig_valid` high for one cycle with 32'h0000_1234; `sig_count`=1.
- Backpressure and overflow (`DEPTH`=8): 10 stores of values 1..10 to 0xF00 with `sig_ready`=0 -> `overflow`=1 and `sig_count`=8. Then raise `sig_ready` -> words 1..8 emerge in order.
- Full FIFO with simultaneous push and pop: FIFO full, store 32'hAA to 0xF00 while popping -> no overflow; 32'hAA emerges last.
- Halt with drain: 3 words queued, store 32'hCAFE_BEEF to 0xF04, hold `sig_ready`=0 for 5 cycles, then release -> `halt` stays 0 until the third pop and is 1 the next cycle. A later store to 0xF00 is ignored.
- Wrong halt value and reset: store 32'hCAFE_BEEE to 0xF04 -> no halt. Queue 2 words, then assert `rst` -> `sig_valid`=0, `sig_count`=0, nothing emitted.
- With `SIG_TIMEOUT_EN`, `TIMEOUT_CYCLES`=500, no halt store -> `timeout`=1 at cycle 500 after reset release, then `halt`=1 once the FIFO is empty.

Source files
------------

// File: rtl/sig_halt_port.sv
// Signature capture FIFO and halt generator on the data-memory store path.
// Optional watchdog enabled by defining SIG_TIMEOUT_EN.
`timescale 1ns/1ps
module sig_halt_port #(
    parameter logic [31:0] SIG_ADDR       = 32'h0000_0F00,
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0F04,
    parameter logic [31:0] HALT_VALUE     = 32'hCAFE_BEEF,
    parameter int          DEPTH          = 8,
    parameter int          TIMEOUT_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_en,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        sig_valid,
    output logic [31:0] sig_data,
    input  logic        sig_ready,
    output logic [15:0] sig_count,
    output logic        overflow,
    output logic        halt,
    output logic        timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   OCC_ONE  = 1;
    localparam logic [AW:0]   OCC_FULL = DEPTH[AW:0];
    localparam logic [31:0]   TO_LIMIT = TIMEOUT_CYCLES[31:0];

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d, occ_left_s;
    logic          sig_valid_q, sig_valid_d;
    logic [31:0]   sig_data_q, sig_data_d;
    logic [15:0]   sig_count_q, sig_count_d;
    logic          overflow_q, overflow_d;
    logic          halt_q, halt_d;
    logic [31:0]   mem_q [DEPTH];
    logic          pop_s, push_req_s, push_s, full_s, halt_req_s, to_hit_s;

`ifdef SIG_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;

    // Watchdog: counts cycles until the block halts.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        to_hit_s  = 1'b0;
        if (state_q != ST_HALTED) begin
            to_cnt_d = to_cnt_q + 32'd1;
            if (to_cnt_d == TO_LIMIT) begin
                to_hit_s  = 1'b1;
                timeout_d = 1'b1;
            end else begin
                to_hit_s  = 1'b0;
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_to_limit_s;
    assign unused_to_limit_s = ^TO_LIMIT;
    assign to_hit_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // FIFO bookkeeping, head register and halt state machine next-state.
    always_comb begin
        pop_s      = sig_valid_q & sig_ready;
        push_req_s = st_en & (st_addr == SIG_ADDR) & (state_q == ST_RUN);
        halt_req_s = st_en & (st_addr == HALT_ADDR) & (st_data == HALT_VALUE);
        full_s     = (occ_q == OCC_FULL);
        push_s     = push_req_s & (~full_s | pop_s);

        wr_ptr_d    = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        occ_left_s  = pop_s ? occ_q - OCC_ONE : occ_q;
        occ_d       = push_s ? occ_left_s + OCC_ONE : occ_left_s;
        overflow_d  = overflow_q | (push_req_s & ~push_s);

        if (push_s && (sig_count_q != 16'hFFFF)) begin
            sig_count_d = sig_count_q + 16'd1;
        end else begin
            sig_count_d = sig_count_q;
        end

        // A word pushed into an empty FIFO only becomes visible a cycle later.
        sig_valid_d = (occ_q != {(AW+1){1'b0}}) & (occ_d != {(AW+1){1'b0}});
        if (occ_left_s != {(AW+1){1'b0}}) begin
            sig_data_d = mem_q[rd_ptr_d];
        end else if (push_s) begin
            sig_data_d = st_data;
        end else begin
            sig_data_d = sig_data_q;
        end

        case (state_q)
            ST_RUN: begin
                if (halt_req_s || to_hit_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (occ_d == {(AW+1){1'b0}}) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        halt_d = (state_d == ST_HALTED);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            occ_q       <= {(AW+1){1'b0}};
            sig_valid_q <= 1'b0;
            sig_data_q  <= 32'd0;
            sig_count_q <= 16'd0;
            overflow_q  <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            sig_valid_q <= sig_valid_d;
            sig_data_q  <= sig_data_d;
            sig_count_q <= sig_count_d;
            overflow_q  <= overflow_d;
            halt_q      <= halt_d;
        end
    end

    // FIFO storage; contents are abandoned on reset via the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= st_data;
        end
    end

    assign sig_valid = sig_valid_q;
    assign sig_data  = sig_data_q;
    assign sig_count = sig_count_q;
    assign overflow  = overflow_q;
    assign halt      = halt_q;
endmodule
